axi_to_reg_v: RTL and testbench
===============================

// Module: axi_to_reg_v
// PURPOSE
//  AXI4 subordinate that turns each AXI beat into one register-interface request, one at a time.
//  Counterpart of the reg-to-AXI bridge: lets an AXI manager (e.g. DMA frontend) reach reg-bus peripherals.
//  One transaction in flight. Bursts are split into sequential reg accesses. B/R responses are built from reg_rsp_error.
// PARAMETERS
//  AxiDataWidth  64  AXI and reg data width (bits); strobe width is AxiDataWidth/8
//  AxiAddrWidth  64  AXI and reg address width
//  AxiIdWidth    1   AXI ID width; ID is echoed on B/R
//  AxiUserWidth  1   AXI user width; inputs ignored, outputs driven 0
// PORTS
//  clk_i  in  1  clock
//  rst_ni  in  1  asynchronous active-low reset
//  axi_req_aw_{id,addr,len,size,burst,atop,valid}  in  per AXI4  write address (lock/cache/prot/qos/region/user ignored)
//  axi_rsp_aw_ready  out  1  write address accept
//  axi_req_w_{data,strb,last,valid}  in  per AXI4  write data (w_user ignored)
//  axi_rsp_w_ready  out  1  write data accept
//  axi_rsp_b_{id,resp,user,valid}  out  per AXI4  write response
//  axi_req_b_ready  in  1  write response accept
//  axi_req_ar_{id,addr,len,size,burst,valid}  in  per AXI4  read address (other AR fields ignored)
//  axi_rsp_ar_ready  out  1  read address accept
//  axi_rsp_r_{id,data,resp,last,user,valid}  out  per AXI4  read data
//  axi_req_r_ready  in  1  read data accept
//  reg_req_{addr,write,wdata,wstrb,valid}  out  Addr/1/Data/Data/8/1  register request
//  reg_rsp_{rdata,error,ready}  in  Data/1/1  register response
// BEHAVIOUR
//  Reset: every valid/ready output 0, all data/id/resp outputs 0, FSM IDLE, arbiter points to write.
//  FSM: IDLE, WR_DATA, WR_REG, WR_RESP, RD_REG, RD_RESP.
//  IDLE: aw_ready/ar_ready are high only for the channel the arbiter selects.
//   If both are valid, round-robin: the winner alternates and write wins first after reset.
//   If only one is valid, it wins. Handshake latches id/addr/len/size/burst, clears beat counter and error flag.
//   AW goes to WR_DATA. AR goes to RD_REG.
//  WR_DATA: w_ready=1. On W handshake, latch data/strb and go to WR_REG.
//  WR_REG: reg_req_valid=1, write=1, addr/wdata/wstrb held stable until reg_rsp_ready.
//   On ready: OR reg_rsp_error into the error flag.
//   If beat==len go to WR_RESP, else advance the address and go to WR_DATA.
//  WR_RESP: b_valid=1, b_resp = error ? 2'b10 (SLVERR) : 2'b00, b_id = latched id.
//   Held until b_ready, then IDLE.
//  RD_REG: reg_req_valid=1, write=0, wstrb=0. On reg_rsp_ready, latch rdata/error and go to RD_RESP.
//  RD_RESP: r_valid=1 with latched data, r_resp per beat (10 on error), r_last = (beat==len), id echoed.
//   On r_ready: if last go to IDLE, else advance the address and go to RD_REG.
//  Address advance: FIXED keeps the address. INCR/WRAP add 1<<size, wrapping modulo 2^AxiAddrWidth.
//   WRAP is treated as INCR.
//  Unsupported request (atop!=0 or size > log2(AxiDataWidth/8)): no reg access is issued.
//   Write: all len+1 W beats are still drained, then B=SLVERR. Read: len+1 beats with resp=SLVERR, data 0.
//  Beat count comes from aw_len only. w_last is ignored; extra W beats are not accepted until the next AW.
//  Latency, zero-wait reg slave:
//   write beat = 2 cycles (W -> reg). b_valid rises 1 cycle after the last reg ack.
//   read beat = 2 cycles (reg -> R).
//  All handshakes follow AXI rules: valid never drops before ready. reg_req_valid is held until reg_rsp_ready.
//  Async reset mid-transaction aborts immediately: outstanding B/R are never issued, reg_req_valid drops.
// TESTING
//  1. AW addr=0x100 len=0 size=3, W data=0xDEAD_BEEF strb=0xFF; reg ready same cycle
//     -> one reg write @0x100, then B resp=00 id echoed.
//  2. AR addr=0x200 len=3 INCR size=3; reg returns 0x1..0x4
//     -> reg reads @0x200,0x208,0x210,0x218; 4 R beats, r_last only on the 4th.
//  3. AW and AR valid in the same cycle after reset -> AW served first; the next simultaneous pair serves AR first.
//  4. 4-beat write, reg_rsp_error=1 on beat 2 -> all 4 reg writes are issued, single B resp=10.
//  5. AW atop=6'h20 len=1 -> 2 W beats accepted, no reg_req_valid, B resp=10.
//  6. Backpressure: hold r_ready/b_ready low for 5 cycles -> valid and payload stay stable.
//     Then assert rst_ni=0 mid-burst -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/axi_to_reg_v.sv
// AXI4 subordinate that serialises every AXI beat into one register-bus access.
// One transaction in flight; AW/AR contention is arbitrated round-robin, write first after reset.
module axi_to_reg_v #(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiIdWidth   = 1,
    parameter int unsigned AxiUserWidth = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // write address
    input  logic [AxiIdWidth-1:0]     axi_req_aw_id,
    input  logic [AxiAddrWidth-1:0]   axi_req_aw_addr,
    input  logic [7:0]                axi_req_aw_len,
    input  logic [2:0]                axi_req_aw_size,
    input  logic [1:0]                axi_req_aw_burst,
    input  logic [5:0]                axi_req_aw_atop,
    input  logic                      axi_req_aw_valid,
    output logic                      axi_rsp_aw_ready,
    // write data
    input  logic [AxiDataWidth-1:0]   axi_req_w_data,
    input  logic [AxiDataWidth/8-1:0] axi_req_w_strb,
    input  logic                      axi_req_w_last,
    input  logic                      axi_req_w_valid,
    output logic                      axi_rsp_w_ready,
    // write response
    output logic [AxiIdWidth-1:0]     axi_rsp_b_id,
    output logic [1:0]                axi_rsp_b_resp,
    output logic [AxiUserWidth-1:0]   axi_rsp_b_user,
    output logic                      axi_rsp_b_valid,
    input  logic                      axi_req_b_ready,
    // read address
    input  logic [AxiIdWidth-1:0]     axi_req_ar_id,
    input  logic [AxiAddrWidth-1:0]   axi_req_ar_addr,
    input  logic [7:0]                axi_req_ar_len,
    input  logic [2:0]                axi_req_ar_size,
    input  logic [1:0]                axi_req_ar_burst,
    input  logic                      axi_req_ar_valid,
    output logic                      axi_rsp_ar_ready,
    // read data
    output logic [AxiIdWidth-1:0]     axi_rsp_r_id,
    output logic [AxiDataWidth-1:0]   axi_rsp_r_data,
    output logic [1:0]                axi_rsp_r_resp,
    output logic                      axi_rsp_r_last,
    output logic [AxiUserWidth-1:0]   axi_rsp_r_user,
    output logic                      axi_rsp_r_valid,
    input  logic                      axi_req_r_ready,
    // register bus
    output logic [AxiAddrWidth-1:0]   reg_req_addr,
    output logic                      reg_req_write,
    output logic [AxiDataWidth-1:0]   reg_req_wdata,
    output logic [AxiDataWidth/8-1:0] reg_req_wstrb,
    output logic                      reg_req_valid,
    input  logic [AxiDataWidth-1:0]   reg_rsp_rdata,
    input  logic                      reg_rsp_error,
    input  logic                      reg_rsp_ready
);

    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam logic [2:0] MaxSize = 3'($clog2(StrbW));
    localparam logic [AxiAddrWidth-1:0] AddrOne = {{(AxiAddrWidth-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_REG, WR_RESP, RD_REG, RD_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic                      prio_wr_q;
    logic [AxiIdWidth-1:0]     id_q;
    logic [AxiAddrWidth-1:0]   addr_q;
    logic [7:0]                len_q, beat_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      err_q, unsup_q;
    logic [AxiDataWidth-1:0]   data_q;
    logic [StrbW-1:0]          strb_q;

    logic aw_sel, ar_sel, aw_hs, ar_hs, w_hs, reg_ack, last_beat, advance, err_in;
    logic [AxiAddrWidth-1:0] next_addr;
    logic unused_w_last;

    assign unused_w_last = axi_req_w_last;

    // A lone request always wins; under contention the priority pointer decides.
    assign aw_sel = axi_req_aw_valid && (!axi_req_ar_valid || prio_wr_q);
    assign ar_sel = axi_req_ar_valid && (!axi_req_aw_valid || !prio_wr_q);

    assign aw_hs     = axi_rsp_aw_ready && axi_req_aw_valid;
    assign ar_hs     = axi_rsp_ar_ready && axi_req_ar_valid;
    assign w_hs      = axi_rsp_w_ready && axi_req_w_valid;
    assign last_beat = (beat_q == len_q);
    assign err_in    = unsup_q || reg_rsp_error;
    // Unsupported requests never touch the reg bus; their beats complete on their own.
    assign reg_ack   = ((state_q == WR_REG) || (state_q == RD_REG)) && (unsup_q || reg_rsp_ready);
    assign advance   = ((state_q == WR_REG) && reg_ack && !last_beat) ||
                       ((state_q == RD_RESP) && axi_req_r_ready && !last_beat);
    assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (AddrOne << size_q);

    assign reg_req_addr   = addr_q;
    assign reg_req_wdata  = data_q;
    assign axi_rsp_b_id   = id_q;
    assign axi_rsp_r_id   = id_q;
    assign axi_rsp_r_data = data_q;
    assign axi_rsp_b_resp = err_q ? 2'b10 : 2'b00;
    assign axi_rsp_r_resp = err_q ? 2'b10 : 2'b00;
    assign axi_rsp_b_user = '0;
    assign axi_rsp_r_user = '0;

    always_comb begin
        state_d          = state_q;
        axi_rsp_aw_ready = 1'b0;
        axi_rsp_ar_ready = 1'b0;
        axi_rsp_w_ready  = 1'b0;
        axi_rsp_b_valid  = 1'b0;
        axi_rsp_r_valid  = 1'b0;
        axi_rsp_r_last   = 1'b0;
        reg_req_valid    = 1'b0;
        reg_req_write    = 1'b0;
        reg_req_wstrb    = '0;
        unique case (state_q)
            IDLE: begin
                axi_rsp_aw_ready = aw_sel;
                axi_rsp_ar_ready = ar_sel;
                if (aw_sel) begin
                    state_d = WR_DATA;
                end else if (ar_sel) begin
                    state_d = RD_REG;
                end
            end
            WR_DATA: begin
                axi_rsp_w_ready = 1'b1;
                if (axi_req_w_valid) state_d = WR_REG;
            end
            WR_REG: begin
                reg_req_valid = !unsup_q;
                reg_req_write = 1'b1;
                reg_req_wstrb = strb_q;
                if (reg_ack) state_d = last_beat ? WR_RESP : WR_DATA;
            end
            WR_RESP: begin
                axi_rsp_b_valid = 1'b1;
                if (axi_req_b_ready) state_d = IDLE;
            end
            RD_REG: begin
                reg_req_valid = !unsup_q;
                if (reg_ack) state_d = RD_RESP;
            end
            RD_RESP: begin
                axi_rsp_r_valid = 1'b1;
                axi_rsp_r_last  = last_beat;
                if (axi_req_r_ready) state_d = last_beat ? IDLE : RD_REG;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            unsup_q   <= 1'b0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q    <= axi_req_aw_id;
                addr_q  <= axi_req_aw_addr;
                len_q   <= axi_req_aw_len;
                size_q  <= axi_req_aw_size;
                burst_q <= axi_req_aw_burst;
                beat_q  <= '0;
                err_q   <= 1'b0;
                unsup_q <= (axi_req_aw_atop != 6'd0) || (axi_req_aw_size > MaxSize);
            end else if (ar_hs) begin
                id_q    <= axi_req_ar_id;
                addr_q  <= axi_req_ar_addr;
                len_q   <= axi_req_ar_len;
                size_q  <= axi_req_ar_size;
                burst_q <= axi_req_ar_burst;
                beat_q  <= '0;
                err_q   <= 1'b0;
                unsup_q <= (axi_req_ar_size > MaxSize);
            end
            // Priority only flips when both channels actually competed.
            if (axi_req_aw_valid && axi_req_ar_valid && (aw_hs || ar_hs)) begin
                prio_wr_q <= ar_hs;
            end
            if (w_hs) begin
                data_q <= axi_req_w_data;
                strb_q <= axi_req_w_strb;
            end
            if (reg_ack) begin
                if (state_q == WR_REG) begin
                    err_q <= err_q || err_in;
                end else begin
                    err_q  <= err_in;
                    data_q <= unsup_q ? '0 : reg_rsp_rdata;
                end
            end
            if (advance) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_addr;
            end
        end
    end

endmodule

// File: tb/tb_axi_to_reg_v.sv
// Directed bench for axi_to_reg_v: a zero-wait reg slave model plus a linear sequence of AXI transactions.
module tb_axi_to_reg_v;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [0:0]  aw_id = '0, ar_id = '0;
    logic [63:0] aw_addr = '0, ar_addr = '0;
    logic [7:0]  aw_len = '0, ar_len = '0;
    logic [2:0]  aw_size = '0, ar_size = '0;
    logic [1:0]  aw_burst = '0, ar_burst = '0;
    logic [5:0]  aw_atop = '0;
    logic        aw_valid = 1'b0, ar_valid = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0, w_valid = 1'b0;
    logic        b_ready = 1'b0, r_ready = 1'b0;
    logic        aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last;
    logic [0:0]  b_id, r_id, b_user, r_user;
    logic [1:0]  b_resp, r_resp;
    logic [63:0] r_data;
    logic [63:0] rq_addr, rq_wdata, rs_rdata;
    logic [7:0]  rq_wstrb;
    logic        rq_write, rq_valid, rs_error, rs_ready;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_log = 0;
    int n_rv  = 0;
    logic [63:0] log_addr [0:127];
    logic [63:0] log_data [0:127];
    logic [7:0]  log_strb [0:127];
    logic        log_wr   [0:127];

    always #5 clk = ~clk;

    // Zero-wait register slave: read data encodes the 8-byte word index above 0x200.
    assign rs_ready = 1'b1;
    assign rs_rdata = ((rq_addr - 64'h200) >> 3) + 64'd1;
    assign rs_error = err_en && (rq_addr == err_addr);

    always @(negedge clk) begin
        if (rq_valid) n_rv <= n_rv + 1;
        if (rq_valid && rs_ready) begin
            log_addr[n_log] <= rq_addr;
            log_data[n_log] <= rq_wdata;
            log_strb[n_log] <= rq_wstrb;
            log_wr[n_log]   <= rq_write;
            n_log           <= n_log + 1;
        end
    end

    axi_to_reg_v dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .axi_req_aw_id(aw_id), .axi_req_aw_addr(aw_addr), .axi_req_aw_len(aw_len),
        .axi_req_aw_size(aw_size), .axi_req_aw_burst(aw_burst), .axi_req_aw_atop(aw_atop),
        .axi_req_aw_valid(aw_valid), .axi_rsp_aw_ready(aw_ready),
        .axi_req_w_data(w_data), .axi_req_w_strb(w_strb), .axi_req_w_last(w_last),
        .axi_req_w_valid(w_valid), .axi_rsp_w_ready(w_ready),
        .axi_rsp_b_id(b_id), .axi_rsp_b_resp(b_resp), .axi_rsp_b_user(b_user),
        .axi_rsp_b_valid(b_valid), .axi_req_b_ready(b_ready),
        .axi_req_ar_id(ar_id), .axi_req_ar_addr(ar_addr), .axi_req_ar_len(ar_len),
        .axi_req_ar_size(ar_size), .axi_req_ar_burst(ar_burst),
        .axi_req_ar_valid(ar_valid), .axi_rsp_ar_ready(ar_ready),
        .axi_rsp_r_id(r_id), .axi_rsp_r_data(r_data), .axi_rsp_r_resp(r_resp),
        .axi_rsp_r_last(r_last), .axi_rsp_r_user(r_user), .axi_rsp_r_valid(r_valid),
        .axi_req_r_ready(r_ready),
        .reg_req_addr(rq_addr), .reg_req_write(rq_write), .reg_req_wdata(rq_wdata),
        .reg_req_wstrb(rq_wstrb), .reg_req_valid(rq_valid),
        .reg_rsp_rdata(rs_rdata), .reg_rsp_error(rs_error), .reg_rsp_ready(rs_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    task automatic aw_put(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
        bit got = 0;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_atop = atop;
        aw_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1; if (aw_ready) got = 1;
            @(negedge clk);
        end
        aw_valid = 1'b0;
        chk("aw_handshake", 64'(got), 64'd1);
    endtask

    task automatic ar_put(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        bit got = 0;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        ar_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1; if (ar_ready) got = 1;
            @(negedge clk);
        end
        ar_valid = 1'b0;
        chk("ar_handshake", 64'(got), 64'd1);
    endtask

    task automatic w_put(input logic [63:0] data, input logic [7:0] strb);
        bit got = 0;
        w_data = data; w_strb = strb; w_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1; if (w_ready) got = 1;
            @(negedge clk);
        end
        w_valid = 1'b0;
        chk("w_handshake", 64'(got), 64'd1);
    endtask

    task automatic b_take(input logic [0:0] id, input logic [1:0] resp);
        bit got = 0;
        b_ready = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (b_valid) begin
                got = 1;
                chk("b_id", 64'(b_id), 64'(id));
                chk("b_resp", 64'(b_resp), 64'(resp));
            end
            @(negedge clk);
        end
        b_ready = 1'b0;
        chk("b_handshake", 64'(got), 64'd1);
    endtask

    task automatic r_take(input logic [63:0] data, input logic [1:0] resp, input logic last,
                          input logic [0:0] id);
        bit got = 0;
        r_ready = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (r_valid) begin
                got = 1;
                chk("r_data", r_data, data);
                chk("r_resp", 64'(r_resp), 64'(resp));
                chk("r_last", 64'(r_last), 64'(last));
                chk("r_id", 64'(r_id), 64'(id));
            end
            @(negedge clk);
        end
        r_ready = 1'b0;
        chk("r_handshake", 64'(got), 64'd1);
    endtask

    initial begin
        int base;
        int rv0;
        bit got;
        logic [63:0] wd [4];
        logic [7:0]  ws [4];
        wd[0] = 64'h1111; wd[1] = 64'h2222; wd[2] = 64'h3333; wd[3] = 64'h4444;
        ws[0] = 8'hFF;    ws[1] = 8'h0F;    ws[2] = 8'hF0;    ws[3] = 8'h01;

        // reset state
        #2;
        chk("rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(ar_ready), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_reg_valid", 64'(rq_valid), 64'd0);
        chk("rst_r_data", r_data, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // simultaneous AW/AR: write first, then the next contended pair goes to read
        aw_id = 1'b0; aw_addr = 64'h600; aw_len = 8'd0; aw_size = 3'd3; aw_burst = 2'b01; aw_atop = '0;
        ar_id = 1'b1; ar_addr = 64'h200; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'b01;
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1;
        chk("arb1_aw_ready", 64'(aw_ready), 64'd1);
        chk("arb1_ar_ready", 64'(ar_ready), 64'd0);
        @(negedge clk);
        aw_valid = 1'b0;
        #1;
        chk("arb1_ar_wait", 64'(ar_ready), 64'd0);
        w_put(64'h55, 8'hFF);
        b_take(1'b0, 2'b00);
        #1;
        chk("arb1_ar_alone", 64'(ar_ready), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        r_take(64'd1, 2'b00, 1'b1, 1'b1);
        aw_id = 1'b1; aw_addr = 64'h608;
        ar_id = 1'b0; ar_addr = 64'h208;
        aw_valid = 1'b1; ar_valid = 1'b1;
        #1;
        chk("arb2_aw_ready", 64'(aw_ready), 64'd0);
        chk("arb2_ar_ready", 64'(ar_ready), 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        r_take(64'd2, 2'b00, 1'b1, 1'b0);
        #1;
        chk("arb2_aw_ready_after", 64'(aw_ready), 64'd1);
        @(negedge clk);
        aw_valid = 1'b0;
        w_put(64'h66, 8'hFF);
        b_take(1'b1, 2'b00);

        // single write beat with latency checks
        base = n_log;
        aw_put(1'b1, 64'h100, 8'd0, 3'd3, 2'b01, 6'd0);
        w_put(64'hDEAD_BEEF, 8'hFF);
        #1;
        chk("t1_reg_valid", 64'(rq_valid), 64'd1);
        chk("t1_reg_write", 64'(rq_write), 64'd1);
        chk("t1_reg_addr", rq_addr, 64'h100);
        chk("t1_reg_wdata", rq_wdata, 64'hDEAD_BEEF);
        chk("t1_reg_wstrb", 64'(rq_wstrb), 64'hFF);
        @(negedge clk);
        #1;
        chk("t1_b_valid_latency", 64'(b_valid), 64'd1);
        b_take(1'b1, 2'b00);
        chk("t1_reg_count", 64'(n_log - base), 64'd1);

        // 4-beat INCR read
        base = n_log;
        ar_put(1'b0, 64'h200, 8'd3, 3'd3, 2'b01);
        r_take(64'd1, 2'b00, 1'b0, 1'b0);
        r_take(64'd2, 2'b00, 1'b0, 1'b0);
        r_take(64'd3, 2'b00, 1'b0, 1'b0);
        r_take(64'd4, 2'b00, 1'b1, 1'b0);
        chk("t2_reg_count", 64'(n_log - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_reg_addr", log_addr[base + k], 64'h200 + 64'(8 * k));
            chk("t2_reg_write", 64'(log_wr[base + k]), 64'd0);
        end

        // 4-beat write, error on second beat, B backpressured
        err_en = 1'b1; err_addr = 64'h308;
        base = n_log;
        aw_put(1'b1, 64'h300, 8'd3, 3'd3, 2'b01, 6'd0);
        for (int k = 0; k < 4; k++) w_put(wd[k], ws[k]);
        @(negedge clk);
        b_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_b_hold_valid", 64'(b_valid), 64'd1);
            chk("t4_b_hold_resp", 64'(b_resp), 64'h2);
            @(negedge clk);
        end
        b_take(1'b1, 2'b10);
        err_en = 1'b0;
        chk("t4_reg_count", 64'(n_log - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t4_reg_addr", log_addr[base + k], 64'h300 + 64'(8 * k));
            chk("t4_reg_wdata", log_data[base + k], wd[k]);
            chk("t4_reg_wstrb", 64'(log_strb[base + k]), 64'(ws[k]));
        end

        // atomic write is drained without reg traffic
        rv0 = n_rv;
        aw_put(1'b0, 64'h400, 8'd1, 3'd3, 2'b01, 6'h20);
        w_put(64'hA, 8'hFF);
        w_put(64'hB, 8'hFF);
        b_take(1'b0, 2'b10);
        chk("t5_no_reg_valid", 64'(n_rv - rv0), 64'd0);

        // oversized read: SLVERR with zero data, no reg traffic
        rv0 = n_rv;
        ar_put(1'b1, 64'h200, 8'd0, 3'd4, 2'b01);
        r_take(64'd0, 2'b10, 1'b1, 1'b1);
        chk("unsup_rd_no_reg", 64'(n_rv - rv0), 64'd0);

        // FIXED burst keeps the address
        base = n_log;
        ar_put(1'b0, 64'h500, 8'd1, 3'd3, 2'b00);
        r_take(64'h61, 2'b00, 1'b0, 1'b0);
        r_take(64'h61, 2'b00, 1'b1, 1'b0);
        chk("fixed_addr0", log_addr[base], 64'h500);
        chk("fixed_addr1", log_addr[base + 1], 64'h500);

        // R backpressure then asynchronous reset mid-burst
        ar_put(1'b1, 64'h200, 8'd3, 3'd3, 2'b01);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1; if (r_valid) got = 1;
            @(negedge clk);
        end
        chk("t6_r_valid_seen", 64'(got), 64'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t6_r_hold_valid", 64'(r_valid), 64'd1);
            chk("t6_r_hold_data", r_data, 64'd1);
            chk("t6_r_hold_last", 64'(r_last), 64'd0);
            @(negedge clk);
        end
        r_take(64'd1, 2'b00, 1'b0, 1'b1);
        #1;
        chk("t6_pre_rst_reg_valid", 64'(rq_valid), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_reg_valid", 64'(rq_valid), 64'd0);
        chk("t6_rst_reg_addr", rq_addr, 64'd0);
        chk("t6_rst_r_valid", 64'(r_valid), 64'd0);
        chk("t6_rst_r_data", r_data, 64'd0);
        chk("t6_rst_r_id", 64'(r_id), 64'd0);
        chk("t6_rst_b_valid", 64'(b_valid), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        r_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_post_rst_r_valid", 64'(r_valid), 64'd0);
        chk("t6_post_rst_reg_valid", 64'(rq_valid), 64'd0);
        r_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
